// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: measures sampled VGA sync timing, tracks lock, and emits active-area pixels with coordinates
module vga_sync_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_START     = 144,
    parameter int V_START     = 35,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pix_en,
    input  logic       i_hsync,
    input  logic       i_vsync,
    input  logic [3:0] i_red,
    input  logic [3:0] i_green,
    input  logic [3:0] i_blue,
    output logic [3:0] o_red,
    output logic [3:0] o_green,
    output logic [3:0] o_blue,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_valid,
    output logic       o_locked,
    output logic       o_frame_start,
    output logic       o_error,
    output logic [9:0] o_line_len,
    output logic [9:0] o_frame_lines
);
    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;
    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam logic [9:0] HT = 10'(H_TOTAL);
    localparam logic [9:0] VT = 10'(V_TOTAL);
    localparam logic [9:0] HS = 10'(H_START);
    localparam logic [9:0] VS = 10'(V_START);
    localparam logic [10:0] HE = 11'(H_START + H_ACTIVE);
    localparam logic [10:0] VE = 11'(V_START + V_ACTIVE);
    localparam logic [GW-1:0] LF = LOCK_FRAMES[GW-1:0];

    state_t state;
    logic [9:0] h_cnt, v_cnt, h_inc, v_inc;
    logic [GW-1:0] good_cnt, good_nxt;
    logic prev_h, prev_v, pending, bad;
    logic hf, vf, fs, sat_hit, line_bad, len_bad, frame_bad, qual;

    always_comb begin
        hf        = prev_h & ~i_hsync;
        vf        = prev_v & ~i_vsync;
        fs        = hf & (pending | vf);
        h_inc     = h_cnt + 10'd1;
        v_inc     = v_cnt + 10'd1;
        good_nxt  = good_cnt + 1'b1;
        // saturation counts as a bad line only on the sample that reaches 1023
        sat_hit   = ~hf & (h_cnt == 10'd1022);
        line_bad  = (hf & (h_inc != HT)) | sat_hit;
        len_bad   = v_inc != VT;
        frame_bad = bad | line_bad | len_bad;
        qual      = (state == LOCKED) && (h_cnt >= HS) && ({1'b0, h_cnt} < HE)
                    && (v_cnt >= VS) && ({1'b0, v_cnt} < VE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= SEARCH;
            h_cnt         <= '0;
            v_cnt         <= '0;
            good_cnt      <= '0;
            prev_h        <= 1'b1;
            prev_v        <= 1'b1;
            pending       <= 1'b0;
            bad           <= 1'b0;
            o_red         <= '0;
            o_green       <= '0;
            o_blue        <= '0;
            o_x           <= '0;
            o_y           <= '0;
            o_valid       <= 1'b0;
            o_locked      <= 1'b0;
            o_frame_start <= 1'b0;
            o_error       <= 1'b0;
            o_line_len    <= '0;
            o_frame_lines <= '0;
        end else if (!pix_en) begin
            o_valid       <= 1'b0;
            o_frame_start <= 1'b0;
            o_error       <= 1'b0;
        end else begin
            prev_h        <= i_hsync;
            prev_v        <= i_vsync;
            h_cnt         <= hf ? '0 : (&h_cnt ? h_cnt : h_inc);
            pending       <= ~fs & (pending | vf);
            o_frame_start <= fs;
            o_valid       <= qual;
            o_error       <= 1'b0;
            if (hf) begin
                o_line_len <= h_inc;
                v_cnt      <= fs ? '0 : (&v_cnt ? v_cnt : v_inc);
            end
            if (fs)
                o_frame_lines <= v_inc;
            if (qual) begin
                o_x     <= h_cnt - HS;
                o_y     <= v_cnt - VS;
                o_red   <= i_red;
                o_green <= i_green;
                o_blue  <= i_blue;
            end
            case (state)
                SEARCH: if (fs) begin
                    state    <= CHECK;
                    good_cnt <= '0;
                    bad      <= 1'b0;
                end
                CHECK: if (fs) begin
                    bad      <= 1'b0;
                    good_cnt <= frame_bad ? '0 : good_nxt;
                    if (!frame_bad && good_nxt == LF) begin
                        state    <= LOCKED;
                        o_locked <= 1'b1;
                    end
                end else if (line_bad) begin
                    bad <= 1'b1;
                end
                LOCKED: if (line_bad || (fs && len_bad)) begin
                    state    <= SEARCH;
                    o_locked <= 1'b0;
                    o_error  <= 1'b1;
                end
                default: state <= SEARCH;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: scoreboard bench on a reduced 20x12 raster, pix_en every second clock
module tb_vga_sync_decoder;
    localparam int H = 20, V = 12, HSW = 2, VSW = 2, HST = 4, VST = 3, HA = 12, VA = 6, LK = 2;

    logic clock = 0, reset = 0, pix_en = 0, i_hsync = 1, i_vsync = 1;
    logic [3:0] i_red = 0, i_green = 0, i_blue = 0, o_red, o_green, o_blue;
    logic [9:0] o_x, o_y, o_line_len, o_frame_lines;
    logic o_valid, o_locked, o_frame_start, o_error;
    logic [31:0] sb[$];
    logic [31:0] last_exp = 0, got, exp_w;
    int n_checks = 0, n_fail = 0, fs_cnt = 0, err_cnt = 0, valid_cnt = 0, fs_base = 0, err_base = 0;

    vga_sync_decoder #(.H_TOTAL(H), .V_TOTAL(V), .H_START(HST), .V_START(VST),
                       .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(LK)) dut (
        .clock(clock), .reset(reset), .pix_en(pix_en), .i_hsync(i_hsync), .i_vsync(i_vsync),
        .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
        .o_red(o_red), .o_green(o_green), .o_blue(o_blue), .o_x(o_x), .o_y(o_y),
        .o_valid(o_valid), .o_locked(o_locked), .o_frame_start(o_frame_start), .o_error(o_error),
        .o_line_len(o_line_len), .o_frame_lines(o_frame_lines)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        #2;
        if (o_frame_start) fs_cnt++;
        if (o_error) err_cnt++;
        if (o_valid) begin
            valid_cnt++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL pixel_unexpected: got pulse x=%0d y=%0d, expected none", o_x, o_y);
            end else begin
                got   = {o_x, o_y, o_red, o_green, o_blue};
                exp_w = sb.pop_front();
                if (got !== exp_w) begin
                    n_fail++;
                    $display("FAIL pixel_data: got %h expected %h", got, exp_w);
                end
            end
        end
    end

    task automatic px(input bit hs, input bit vs, input bit q, input int x, input int y);
        @(negedge clock);
        i_hsync = hs;
        i_vsync = vs;
        i_red   = 4'($urandom);
        i_green = 4'($urandom);
        i_blue  = 4'($urandom);
        pix_en  = 1;
        if (q) begin
            last_exp = {x[9:0], y[9:0], i_red, i_green, i_blue};
            sb.push_back(last_exp);
        end
        @(negedge clock);
        pix_en = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        pix_en  = 0;
        i_hsync = 1;
        i_vsync = 1;
        reset   = 0;
        repeat (3) @(negedge clock);
        reset = 1;
        sb.delete();
        fs_base  = fs_cnt;
        err_base = err_cnt;
    endtask

    // tail of a previous frame's last line: vsync falls on its final pixel
    task automatic lead();
        for (int p = HSW; p < H; p++) px(1, p != H - 1, 0, 0, 0);
    endtask

    task automatic gen_frame(input int nl, input int long_l, input bit lk, input int gap_l, input int abort_l);
        int len, hc, v0;
        bit lkl, vlow, q;
        for (int l = 0; l < nl; l++) begin
            len = (l == long_l) ? H + 1 : H;
            lkl = lk && !(long_l >= 0 && l > long_l);
            for (int p = 0; p < len; p++) begin
                hc   = p - 1;
                vlow = (p == len - 1) ? (((l + 1) % nl) < VSW) : (l < VSW);
                q    = lkl && p >= 1 && hc >= HST && hc < HST + HA && l >= VST && l < VST + VA;
                px(p >= HSW, !vlow, q, hc - HST, l - VST);
                if (long_l >= 0 && l == long_l + 1 && p == 0) begin
                    n_checks += 3;
                    if (o_line_len !== 10'(H + 1)) begin n_fail++; $display("FAIL long_line_len: got %0d expected %0d", o_line_len, H + 1); end
                    if (o_locked !== 1'b0) begin n_fail++; $display("FAIL long_line_unlock: got %0b expected 0", o_locked); end
                    if (err_cnt - err_base != 1) begin n_fail++; $display("FAIL long_line_error: got %0d expected 1", err_cnt - err_base); end
                end
                if (l == gap_l && p == 8) begin
                    v0 = valid_cnt;
                    repeat (100) @(negedge clock);
                    n_checks += 4;
                    if (valid_cnt != v0) begin n_fail++; $display("FAIL gap_valid: got %0d expected %0d", valid_cnt, v0); end
                    if ({o_x, o_y, o_red, o_green, o_blue} !== last_exp) begin n_fail++; $display("FAIL gap_hold: got %h expected %h", {o_x, o_y, o_red, o_green, o_blue}, last_exp); end
                    if (o_locked !== 1'b1) begin n_fail++; $display("FAIL gap_locked: got %0b expected 1", o_locked); end
                    if ({o_line_len, o_frame_lines} !== {10'(H), 10'(V)}) begin n_fail++; $display("FAIL gap_meas: got %0d/%0d expected %0d/%0d", o_line_len, o_frame_lines, H, V); end
                end
                if (l == abort_l && p == 8) return;
            end
        end
    endtask

    task automatic relock_seq();
        lead();
        gen_frame(V, -1, 0, -1, -1);
        gen_frame(V, -1, 0, -1, -1);
        gen_frame(V, -1, 1, -1, -1);
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset   = 0;
        pix_en  = 1;
        i_hsync = 0;
        i_vsync = 0;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({o_red, o_green, o_blue, o_x, o_y, o_valid, o_locked, o_frame_start, o_error, o_line_len, o_frame_lines} !== 56'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got nonzero outputs x=%0d len=%0d lines=%0d locked=%0b", o_x, o_line_len, o_frame_lines, o_locked);
        end
        pix_en  = 0;
        i_hsync = 1;
        i_vsync = 1;
        do_reset();
    endtask

    task automatic test_ideal();
        do_reset();
        lead();
        gen_frame(V, -1, 0, -1, -1);
        n_checks += 2;
        if (fs_cnt - fs_base != 1) begin n_fail++; $display("FAIL ideal_fs1: got %0d expected 1", fs_cnt - fs_base); end
        if (o_locked !== 1'b0) begin n_fail++; $display("FAIL ideal_nolock1: got %0b expected 0", o_locked); end
        gen_frame(V, -1, 0, -1, -1);
        n_checks += 2;
        if (o_locked !== 1'b0) begin n_fail++; $display("FAIL ideal_nolock2: got %0b expected 0", o_locked); end
        if (o_frame_lines !== 10'(V)) begin n_fail++; $display("FAIL ideal_lines: got %0d expected %0d", o_frame_lines, V); end
        gen_frame(V, -1, 1, -1, -1);
        n_checks++;
        if (o_locked !== 1'b1) begin n_fail++; $display("FAIL ideal_lock3: got %0b expected 1", o_locked); end
        valid_cnt = 0;
        gen_frame(V, -1, 1, -1, -1);
        n_checks += 4;
        if (valid_cnt != HA * VA) begin n_fail++; $display("FAIL ideal_pixels: got %0d expected %0d", valid_cnt, HA * VA); end
        if (o_line_len !== 10'(H)) begin n_fail++; $display("FAIL ideal_len: got %0d expected %0d", o_line_len, H); end
        if (err_cnt != err_base) begin n_fail++; $display("FAIL ideal_err: got %0d expected 0", err_cnt - err_base); end
        if (fs_cnt - fs_base != 4) begin n_fail++; $display("FAIL ideal_fs4: got %0d expected 4", fs_cnt - fs_base); end
    endtask

    task automatic test_long_line();
        do_reset();
        relock_seq();
        gen_frame(V, 5, 1, -1, -1);
        relock_seq_after_error();
    endtask

    task automatic relock_seq_after_error();
        n_checks++;
        if (o_locked !== 1'b0) begin n_fail++; $display("FAIL relock_pre: got %0b expected 0", o_locked); end
        gen_frame(V, -1, 0, -1, -1);
        gen_frame(V, -1, 0, -1, -1);
        gen_frame(V, -1, 1, -1, -1);
        n_checks += 2;
        if (o_locked !== 1'b1) begin n_fail++; $display("FAIL relock_post: got %0b expected 1", o_locked); end
        if (err_cnt - err_base != 1) begin n_fail++; $display("FAIL relock_err: got %0d expected 1", err_cnt - err_base); end
    endtask

    task automatic test_short_frame();
        do_reset();
        lead();
        gen_frame(V - 1, -1, 0, -1, -1);
        gen_frame(V, -1, 0, -1, -1);
        n_checks += 2;
        if (o_frame_lines !== 10'(V - 1)) begin n_fail++; $display("FAIL short_lines: got %0d expected %0d", o_frame_lines, V - 1); end
        if (o_locked !== 1'b0) begin n_fail++; $display("FAIL short_nolock2: got %0b expected 0", o_locked); end
        gen_frame(V, -1, 0, -1, -1);
        n_checks++;
        if (o_locked !== 1'b0) begin n_fail++; $display("FAIL short_nolock3: got %0b expected 0", o_locked); end
        valid_cnt = 0;
        gen_frame(V, -1, 1, -1, -1);
        n_checks += 2;
        if (o_locked !== 1'b1) begin n_fail++; $display("FAIL short_lock4: got %0b expected 1", o_locked); end
        if (valid_cnt != HA * VA) begin n_fail++; $display("FAIL short_pixels: got %0d expected %0d", valid_cnt, HA * VA); end
    endtask

    task automatic test_saturation();
        do_reset();
        relock_seq();
        for (int p = 0; p < HSW; p++) px(0, 0, 0, 0, 0);
        n_checks++;
        if (o_locked !== 1'b1) begin n_fail++; $display("FAIL sat_prelock: got %0b expected 1", o_locked); end
        repeat (1100) px(1, 0, 0, 0, 0);
        n_checks++;
        if (err_cnt - err_base != 1) begin n_fail++; $display("FAIL sat_error: got %0d expected 1", err_cnt - err_base); end
        lead();
        relock_seq_after_error();
    endtask

    task automatic test_pix_en_gap();
        do_reset();
        relock_seq();
        valid_cnt = 0;
        gen_frame(V, -1, 1, 4, -1);
        n_checks += 2;
        if (valid_cnt != HA * VA) begin n_fail++; $display("FAIL gap_pixels: got %0d expected %0d", valid_cnt, HA * VA); end
        if (err_cnt != err_base || o_locked !== 1'b1) begin n_fail++; $display("FAIL gap_resume: got err=%0d locked=%0b expected err=0 locked=1", err_cnt - err_base, o_locked); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        relock_seq();
        gen_frame(V, -1, 1, -1, 4);
        n_checks += 2;
        if (o_locked !== 1'b1) begin n_fail++; $display("FAIL midrst_prelock: got %0b expected 1", o_locked); end
        #1 reset = 0;
        #1;
        if ({o_red, o_green, o_blue, o_x, o_y, o_valid, o_locked, o_frame_start, o_error, o_line_len, o_frame_lines} !== 56'd0) begin
            n_fail++;
            $display("FAIL midrst_async: got x=%0d y=%0d len=%0d locked=%0b expected all 0", o_x, o_y, o_line_len, o_locked);
        end
        repeat (2) @(negedge clock);
        reset = 1;
        sb.delete();
        fs_base  = fs_cnt;
        err_base = err_cnt;
        lead();
        gen_frame(V, -1, 0, -1, -1);
        gen_frame(V, -1, 0, -1, -1);
        n_checks++;
        if (o_locked !== 1'b0) begin n_fail++; $display("FAIL midrst_nolock: got %0b expected 0", o_locked); end
        gen_frame(V, -1, 1, -1, -1);
        n_checks += 2;
        if (o_locked !== 1'b1) begin n_fail++; $display("FAIL midrst_relock: got %0b expected 1", o_locked); end
        if (fs_cnt - fs_base != 3) begin n_fail++; $display("FAIL midrst_fs: got %0d expected 3", fs_cnt - fs_base); end
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_long_line();
        test_short_frame();
        test_saturation();
        test_pix_en_gap();
        test_reset_mid_frame();
        repeat (4) @(negedge clock);
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d entries expected 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
